// File: rtl/fetch_pkg.sv
// Shared state encoding and default widths for the instruction-fetch sequencer.
// Pure declarations; no logic, no latency.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int          ADDR_W_DEF      = 7;
  localparam int          DATA_W_DEF      = 8;
  localparam logic [7:0]  HALT_OPCODE_DEF = 8'hFF;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with load (priority over increment) and a registered wrap pulse.
// Load/increment take effect on the next edge; wrap is high for the cycle after 2^ADDR_W-1 -> 0.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        pc <= load_val;
      end else if (inc) begin
        pc   <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        wrap <= &pc;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC drives a combinational ROM; returned word is latched one edge later, 1 instr/cycle.
// Holds PC and output word while decode stalls; optional perf counters under FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       fetch_cnt_o,
  output logic [15:0]       branch_cnt_o,
`endif
  output logic              busy_o,
  output logic              halted_o,
  output logic              wrap_o
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_load_val;
  logic              latch, clr_valid, start_acc, branch_acc;
  logic              adv;

  assign adv = !instr_valid_o || instr_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    pc_load_val = START_ADDR;
    pc_inc      = 1'b0;
    latch       = 1'b0;
    clr_valid   = 1'b0;
    start_acc   = 1'b0;
    branch_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          pc_load   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // A redirect flushes the held word even when decode is taking it this cycle.
        if (branch_i) begin
          branch_acc  = 1'b1;
          pc_load     = 1'b1;
          pc_load_val = branch_target_i;
          clr_valid   = 1'b1;
        end else if (adv) begin
          latch = 1'b1;
          if (rom_data_i == HALT_OPCODE) state_nxt = HALTED;
          else                           pc_inc    = 1'b1;
        end
      end
      HALTED: begin
        if (start_i) begin
          start_acc = 1'b1;
          pc_load   = 1'b1;
          clr_valid = 1'b1;
          state_nxt = FETCH;
        end else if (instr_ready_i) begin
          clr_valid = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .wrap     (wrap_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
    end else if (latch) begin
      instr_o       <= rom_data_i;
      instr_pc_o    <= pc;
      instr_valid_o <= 1'b1;
    end else if (clr_valid) begin
      instr_valid_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o  <= '0;
      branch_cnt_o <= '0;
    end else if (start_acc) begin
      fetch_cnt_o  <= '0;
      branch_cnt_o <= '0;
    end else begin
      if (instr_valid_o && instr_ready_i && fetch_cnt_o != 16'hFFFF)
        fetch_cnt_o <= fetch_cnt_o + 16'd1;
      if (branch_acc && branch_cnt_o != 16'hFFFF)
        branch_cnt_o <= branch_cnt_o + 16'd1;
    end
  end
`endif

  assign rom_addr_o = pc;
  assign busy_o     = (state == FETCH);
  assign halted_o   = (state == HALTED);

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 128 x 8 combinational instruction ROM (7-bit address, 8-bit word).
- Owns the program counter and drives the ROM address.
- Latches each returned word into an output register with a valid/ready handshake to decode.
- Handles start, branch redirect, halt-opcode detection and PC wrap-around; sits between the ROM and the decode stage.

Parameters:
- ADDR_W, 7, PC and ROM address width.
- DATA_W, 8, instruction width.
- START_ADDR, 7'h00, PC load value on start.
- HALT_OPCODE, 8'hFF, word that stops fetching once latched.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin fetching from START_ADDR; honoured only in IDLE or HALTED.
- rom_addr_o  out  ADDR_W  ROM address, driven directly from the PC register.
- rom_data_i  in  DATA_W  ROM word, combinational from rom_addr_o.
- instr_o  out  DATA_W  latched instruction.
- instr_pc_o  out  ADDR_W  address instr_o was fetched from.
- instr_valid_o  out  1  instr_o/instr_pc_o hold a valid instruction.
- instr_ready_i  in  1  decode accepts the instruction this cycle.
- branch_i  in  1  redirect request, single-cycle.
- branch_target_i  in  ADDR_W  redirect address.
- busy_o  out  1  state is FETCH.
- halted_o  out  1  state is HALTED.
- wrap_o  out  1  one-cycle pulse when the PC wraps from 2^ADDR_W-1 to 0.

Behaviour:
- Reset (async, immediate) values:
  - state IDLE; PC 0.
  - instr_o 0, instr_pc_o 0, instr_valid_o 0.
  - busy_o 0, halted_o 0, wrap_o 0.
- States: IDLE, FETCH, HALTED.
- IDLE:
  - start_i: PC <= START_ADDR, go to FETCH.
  - branch_i is ignored.
- FETCH, advance condition: adv = !instr_valid_o || instr_ready_i.
- FETCH, priority 1, branch_i:
  - PC <= branch_target_i and instr_valid_o <= 0 (flushes held word, even if ready is high).
  - No latch this cycle; stay in FETCH.
- FETCH, priority 2, adv with no branch:
  - instr_o <= rom_data_i; instr_pc_o <= PC; instr_valid_o <= 1.
  - If rom_data_i == HALT_OPCODE: PC unchanged, go to HALTED.
  - Otherwise PC <= PC+1 (mod 2^ADDR_W). If PC was all-ones, wrap_o <= 1 for one cycle; fetching continues at 0.
- FETCH, priority 3, !adv: hold all registers; ROM address stays stable.
- HALTED:
  - The halt word stays valid until accepted (ready high), then instr_valid_o <= 0.
  - branch_i is ignored.
  - start_i: PC <= START_ADDR, go to FETCH. Any still-valid halt word is discarded (valid <= 0).
- start_i in FETCH is ignored.
- Latency:
  - start_i sampled at edge N: rom_addr_o = START_ADDR after N.
  - First instr_valid_o = 1 after edge N+1.
  - With ready held high, throughput is 1 instruction/cycle.
- Branch latency: branch_i at edge N gives rom_addr_o = target after N and a valid target word after N+1 (one bubble).
- Reset asserted mid-FETCH or in HALTED: immediate return to reset values; no partial handshake survives.
- busy_o and halted_o are decoded from state registers (glitch-free, registered state).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds output fetch_cnt_o [15:0], count of handshakes (instr_valid_o && instr_ready_i).
  - Saturates at 16'hFFFF.
  - Cleared by reset and by an accepted start_i.
  - Adds output branch_cnt_o [15:0], count of honoured branches, same rules.
- When undefined: neither port nor counter exists; all other behaviour identical.

Decomposition:
- fetch_pkg holds:
  - state encoding constants: IDLE=2'd0, FETCH=2'd1, HALTED=2'd2;
  - default ADDR_W/DATA_W;
  - HALT_OPCODE default.
- One sub-module, fetch_pc:
  - PC register with load (start/branch), increment enable, and wrap pulse output;
  - instantiated once inside fetch_ctrl.
- The output register and FSM stay in the top level.

Test Plan:
1. Reset then start. ROM[0..3] = 11,22,33,44; ready = 1; start_i pulse → instr_o = 11,22,33,44 on consecutive cycles; instr_pc_o = 0,1,2,3.
2. Backpressure. ready = 0 for 3 cycles after the first valid word → instr_o holds 11 and rom_addr_o holds 1; resumes with 22 when ready rises, no word lost or duplicated.
3. Branch. branch_i with target 7'h40 while word at PC 5 is valid and ready = 0 → valid drops next cycle; next valid is ROM[0x40] with instr_pc_o = 0x40.
4. Halt. ROM[2] = 8'hFF → 8'hFF presented with instr_pc_o = 2, halted_o = 1, rom_addr_o stays 2; valid clears after accept; start_i restarts at 0.
5. Wrap. Branch to 7'h7E with ROM non-halt throughout → instr_pc_o 0x7E, 0x7F, 0x00; wrap_o pulses exactly once.
6. Async reset. Assert rst_i mid-FETCH between clock edges → outputs zero immediately; no fetch until a new start_i. With FETCH_PERF_CNT_EN defined, fetch_cnt_o = 0.
